// File: rtl/fifo_read_scheduler_pkg.sv
// rtl/fifo_read_scheduler_pkg.sv - shared FSM type and width helpers for the read scheduler
package fifo_read_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  function automatic int src_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int burst_cnt_width(input int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/fifo_read_scheduler_rr_pick.sv
// rtl/fifo_read_scheduler_rr_pick.sv - rotating-priority pick: first set request at or after ptr, wrapping
module rr_pick #(
  parameter int N     = 4,
  parameter int SRC_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  int k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = SRC_W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_read_scheduler.sv
// rtl/fifo_read_scheduler.sv - round-robin burst read scheduler merging N FWFT sources into one tagged stream
module fifo_read_scheduler
  import fifo_read_scheduler_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = 4,
  parameter int BURST  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            src_en,
  output logic [N-1:0]            r_req,
  input  logic [N*DATA_W-1:0]     r_data,
  input  logic [N-1:0]            empty,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [src_width(N)-1:0] out_src,
  input  logic                    out_ready
);

  localparam int SRC_W = src_width(N);
  localparam int CNT_W = burst_cnt_width(BURST);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);

  sched_state_t state, state_n;
  logic [SRC_W-1:0] grant_idx, grant_idx_n;
  logic [SRC_W-1:0] ptr, ptr_n, rot_ptr;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_n, cnt_inc;
  logic [N-1:0]     r_req_n, elig, g_onehot;
  logic             g_elig, rotate;

  logic [N-1:0]     idle_grant, rot_grant;
  logic [SRC_W-1:0] idle_idx, rot_idx;
  logic             idle_any, rot_any;

  logic [DATA_W-1:0] head_data, tail_data, push_data;
  logic [SRC_W-1:0]  head_src, tail_src;
  logic [1:0]        occ, occ_next;
  logic              push, pop, credit;

  assign elig      = src_en & ~empty;
  assign g_elig    = elig[grant_idx];
  assign g_onehot  = {{(N-1){1'b0}}, 1'b1} << grant_idx;
  assign cnt_inc   = burst_cnt + 1'b1;
  assign rot_ptr   = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;

  // r_req is one-hot on grant_idx whenever set, so grant_idx selects the word being returned.
  assign push      = |r_req;
  assign pop       = out_valid & out_ready;
  assign push_data = r_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign occ_next  = occ + {1'b0, push} - {1'b0, pop};
  assign credit    = (occ_next <= 2'd1);

  assign out_valid = (occ != 2'd0);
  assign out_data  = head_data;
  assign out_src   = head_src;

  rr_pick #(.N(N), .SRC_W(SRC_W)) u_pick_idle (
    .req   (elig),
    .ptr   (ptr),
    .grant (idle_grant),
    .idx   (idle_idx),
    .any   (idle_any)
  );

  rr_pick #(.N(N), .SRC_W(SRC_W)) u_pick_rot (
    .req   (elig),
    .ptr   (rot_ptr),
    .grant (rot_grant),
    .idx   (rot_idx),
    .any   (rot_any)
  );

  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    ptr_n       = ptr;
    burst_cnt_n = burst_cnt;
    r_req_n     = '0;
    rotate      = 1'b0;
    case (state)
      IDLE: begin
        if (idle_any && credit) begin
          state_n     = READ;
          grant_idx_n = idle_idx;
          r_req_n     = idle_grant;
          burst_cnt_n = '0;
        end
      end
      READ: begin
        if (g_elig && credit && (cnt_inc < BURST_MAX)) begin
          burst_cnt_n = cnt_inc;
          r_req_n     = g_onehot;
        end else if (g_elig && (cnt_inc < BURST_MAX)) begin
          state_n     = HOLD;
          burst_cnt_n = cnt_inc;
        end else begin
          rotate = 1'b1;
        end
      end
      HOLD: begin
        if (g_elig && credit) begin
          state_n = READ;
          r_req_n = g_onehot;
        end else if (!g_elig) begin
          rotate = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Rotation picks the next source in the same cycle so a burst change costs no bubble.
    if (rotate) begin
      ptr_n       = rot_ptr;
      burst_cnt_n = '0;
      if (rot_any && credit) begin
        state_n     = READ;
        grant_idx_n = rot_idx;
        r_req_n     = rot_grant;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      r_req     <= '0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_idx_n;
      ptr       <= ptr_n;
      burst_cnt <= burst_cnt_n;
      r_req     <= r_req_n;
    end
  end

  // Head/tail pair; head only moves on pop or on a push into an empty buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      head_data <= '0;
      head_src  <= '0;
      tail_data <= '0;
      tail_src  <= '0;
    end else begin
      occ <= occ_next;
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= push_data;
            head_src  <= grant_idx;
          end else begin
            tail_data <= push_data;
            tail_src  <= grant_idx;
          end
        end
        2'b01: begin
          if (occ == 2'd2) begin
            head_data <= tail_data;
            head_src  <= tail_src;
          end
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head_data <= tail_data;
            head_src  <= tail_src;
            tail_data <= push_data;
            tail_src  <= grant_idx;
          end else begin
            head_data <= push_data;
            head_src  <= grant_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// tb/tb_fifo_read_scheduler.sv - directed self-checking bench for fifo_read_scheduler
module tb_fifo_read_scheduler;
  import fifo_read_scheduler_pkg::*;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] src_en;
  logic [NS-1:0] r_req;
  logic [NS*DW-1:0] r_data;
  logic [NS-1:0] empty;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_ready;

  fifo_read_scheduler #(.DATA_W(DW), .N(NS), .BURST(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_en    (src_en),
    .r_req     (r_req),
    .r_data    (r_data),
    .empty     (empty),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // FWFT source model; empty rises combinationally while the last word is being read.
  logic [31:0] smem [4][64];
  int wr [4];
  int rd [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (r_req[i]) rd[i] <= rd[i] + 1;
  end

  always_comb begin
    r_data = '0;
    empty  = '1;
    for (int i = 0; i < 4; i++) begin
      r_data[i*32 +: 32] = smem[i][rd[i] & 63];
      empty[i] = ((wr[i] - rd[i]) == 0) || (((wr[i] - rd[i]) == 1) && r_req[i]);
    end
  end

  int cyc, req_n, cap_n, req_tot, pop_tot, max_buf, onehot_bad;
  int req_src [512];
  int req_cyc [512];
  int cap_cyc [512];
  logic [33:0] cap_word [512];

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (|r_req) begin
      req_src[req_n] <= oh_idx(r_req);
      req_cyc[req_n] <= cyc;
      req_n <= req_n + 1;
    end
    if ($countones(r_req) > 1) onehot_bad <= onehot_bad + 1;
    if (out_valid && out_ready) begin
      cap_word[cap_n] <= {out_src, out_data};
      cap_cyc[cap_n]  <= cyc;
      cap_n <= cap_n + 1;
    end
    if (req_tot - pop_tot > max_buf) max_buf <= req_tot - pop_tot;
    req_tot <= req_tot + ((|r_req) ? 1 : 0);
    pop_tot <= pop_tot + ((out_valid && out_ready) ? 1 : 0);
  end

  int checks = 0;
  int errors = 0;
  int exp_rd [4];

  function automatic logic [31:0] mk(input int s, input int k);
    return {8'(s + 1), 8'h5A, 16'(k)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int pos, input int s);
    check(tag, {30'd0, cap_word[pos]}, {30'd0, 2'(s), mk(s, exp_rd[s])});
    exp_rd[s]++;
  endtask

  task automatic load(input int s, input int n);
    for (int j = 0; j < n; j++) begin
      smem[s][wr[s] & 63] = mk(s, wr[s]);
      wr[s]++;
    end
  endtask

  task automatic do_reset();
    src_en = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && cap_n < n; i++) step();
    check(tag, 64'(cap_n >= n), 64'd1);
  endtask

  int base_c, base_r, seen, e1;

  initial begin
    rst = 1'b1;
    src_en = '0;
    out_ready = 1'b1;
    repeat (2) step();
    check("rst_r_req", 64'(r_req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    rst = 1'b0;
    step();

    // single source, three words
    base_c = cap_n; base_r = req_n;
    load(2, 3);
    src_en = 4'b0100;
    wait_caps(base_c + 3, 50, "t1_timeout");
    repeat (3) step();
    check("t1_req_count", 64'(req_n - base_r), 64'd3);
    check("t1_req_span", 64'(req_cyc[base_r + 2] - req_cyc[base_r]), 64'd2);
    for (int j = 0; j < 3; j++) check("t1_req_src", 64'(req_src[base_r + j]), 64'd2);
    check("t1_latency", 64'(cap_cyc[base_c] - req_cyc[base_r]), 64'd1);
    for (int j = 0; j < 3; j++) chk_word("t1_word", base_c + j, 2);
    check("t1_idle", 64'(dut.state), 64'(IDLE));
    check("t1_drained", 64'(out_valid), 64'd0);

    // four sources, twenty words each, bursts of eight
    do_reset();
    base_c = cap_n;
    for (int s = 0; s < 4; s++) load(s, 20);
    src_en = 4'b1111;
    wait_caps(base_c + 80, 300, "t2_timeout");
    begin
      int pos;
      pos = base_c;
      for (int rnd = 0; rnd < 3; rnd++)
        for (int s = 0; s < 4; s++)
          for (int j = 0; j < ((rnd < 2) ? 8 : 4); j++) begin
            chk_word("t2_word", pos, s);
            pos++;
          end
    end
    check("t2_no_bubble", 64'(cap_cyc[base_c + 79] - cap_cyc[base_c]), 64'd79);
    repeat (3) step();

    // backpressure: ten stalled cycles mid-stream
    do_reset();
    base_c = cap_n;
    load(0, 12);
    src_en = 4'b0001;
    wait_caps(base_c + 4, 50, "t3_pre_timeout");
    out_ready = 1'b0;
    repeat (10) step();
    check("t3_stall_valid", 64'(out_valid), 64'd1);
    check("t3_stall_head", {30'd0, out_src, out_data}, {30'd0, 2'd0, mk(0, exp_rd[0] + 4)});
    check("t3_stall_no_req", 64'(r_req), 64'd0);
    out_ready = 1'b1;
    wait_caps(base_c + 12, 100, "t3_timeout");
    for (int j = 0; j < 12; j++) chk_word("t3_word", base_c + j, 0);
    check("t3_max_buf", 64'(max_buf <= 2), 64'd1);
    check("t3_onehot", 64'(onehot_bad), 64'd0);
    repeat (3) step();

    // source 0 empties after its only word
    do_reset();
    base_c = cap_n; base_r = req_n;
    load(0, 1);
    load(3, 2);
    src_en = 4'b1001;
    wait_caps(base_c + 3, 50, "t5_timeout");
    repeat (2) step();
    check("t5_req_count", 64'(req_n - base_r), 64'd3);
    check("t5_req0", 64'(req_src[base_r]), 64'd0);
    check("t5_req1", 64'(req_src[base_r + 1]), 64'd3);
    check("t5_req2", 64'(req_src[base_r + 2]), 64'd3);
    check("t5_rot_gap", 64'(req_cyc[base_r + 1] - req_cyc[base_r]), 64'd1);
    chk_word("t5_word", base_c, 0);
    chk_word("t5_word", base_c + 1, 3);
    chk_word("t5_word", base_c + 2, 3);

    // src_en[1] drops during source 1's burst
    do_reset();
    base_c = cap_n;
    load(1, 8);
    load(2, 3);
    src_en = 4'b0110;
    seen = 0;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      step();
      if (r_req[1]) seen++;
    end
    check("t4_seen", 64'(seen), 64'd3);
    src_en = 4'b0100;
    wait_caps(base_c + 6, 50, "t4_timeout");
    repeat (3) step();
    check("t4_count", 64'(cap_n - base_c), 64'd6);
    for (int j = 0; j < 3; j++) chk_word("t4_word", base_c + j, 1);
    for (int j = 3; j < 6; j++) chk_word("t4_word", base_c + j, 2);

    // reset in the middle of source 1's second burst
    do_reset();
    load(1, 10);
    e1 = exp_rd[1];
    src_en = 4'b0010;
    seen = 0;
    for (int i = 0; i < 60 && seen < 10; i++) begin
      step();
      if (r_req[1]) seen++;
    end
    check("t6_seen", 64'(seen), 64'd10);
    rst = 1'b1;
    step();
    check("t6_r_req", 64'(r_req), 64'd0);
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_out_data", 64'(out_data), 64'd0);
    check("t6_out_src", 64'(out_src), 64'd0);
    base_c = cap_n; base_r = req_n;
    rst = 1'b0;
    load(3, 2);
    src_en = 4'b1010;
    wait_caps(base_c + 1, 20, "t6_timeout");
    check("t6_first_grant", 64'(req_src[base_r]), 64'd1);
    check("t6_first_word", {30'd0, cap_word[base_c]}, {30'd0, 2'd1, mk(1, e1 + 10)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
